// File: rtl/address_bus_latch_bank_pkg.sv
// Shared constants for the 6502 address-output register: lane width and
// internal bus indices that the per-lane source selects refer to.
package cpu6502_addr_pkg;

   localparam int LANE_W_DEFAULT = 8;

   localparam int SRC_DB  = 0;
   localparam int SRC_ADL = 1;
   localparam int SRC_ADH = 2;
   localparam int SRC_SB  = 3;

   function automatic int sel_w(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

endpackage

// File: rtl/address_bus_latch_bank_if.sv
// Bus-side signals of the address latch bank: source buses and controls in,
// address pins and fix-up status out.
interface address_bus_latch_bank_if
   import cpu6502_addr_pkg::*;
#(
   parameter int LANE_W    = LANE_W_DEFAULT,
   parameter int NUM_LANES = 2,
   parameter int NUM_SRC   = 4,
   parameter int SEL_W     = sel_w(NUM_SRC)
);

   logic                        i_ce;
   logic [NUM_SRC*LANE_W-1:0]   i_src;
   logic [NUM_LANES-1:0]        i_load;
   logic [NUM_LANES*SEL_W-1:0]  i_sel;
   logic                        i_inc;
   logic                        i_carry_in;
   logic [NUM_LANES*LANE_W-1:0] o_address;
   logic                        o_fixup_pending;

   modport master (
      output i_ce, i_src, i_load, i_sel, i_inc, i_carry_in,
      input  o_address, o_fixup_pending
   );

   modport slave (
      input  i_ce, i_src, i_load, i_sel, i_inc, i_carry_in,
      output o_address, o_fixup_pending
   );

endinterface

// File: rtl/address_bus_latch_bank_lane.sv
// One byte lane of the address register: source mux, lane register, phi1
// transparent output and an adder stage that takes one extra addend plus a ripple carry.
module address_bus_lane
   import cpu6502_addr_pkg::*;
#(
   parameter int                LANE_W      = LANE_W_DEFAULT,
   parameter int                NUM_SRC     = 4,
   parameter int                SEL_W       = sel_w(NUM_SRC),
   parameter logic [LANE_W-1:0] RESET_VALUE = '0
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_ce,
   input  logic [NUM_SRC*LANE_W-1:0] i_src,
   input  logic [SEL_W-1:0]          i_sel,
   input  logic                      i_load,
   input  logic                      i_add,
   input  logic                      i_carry,
   output logic                      o_carry,
   output logic [LANE_W-1:0]         o_value
);

   logic [LANE_W-1:0] src_word;
   logic [LANE_W-1:0] r_value;
   logic [LANE_W:0]   sum;

   // Out-of-range selects fall through to zero.
   always_comb begin
      src_word = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (i_sel == SEL_W'(k)) src_word = i_src[k*LANE_W +: LANE_W];
      end
   end

   // A loaded lane never propagates a carry: the load discards it.
   always_comb begin
      sum     = {1'b0, r_value} + (LANE_W+1)'(i_add) + (LANE_W+1)'(i_carry);
      o_carry = sum[LANE_W] & ~i_load;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_value <= RESET_VALUE;
      end else if (i_ce) begin
         r_value <= i_load ? src_word : sum[LANE_W-1:0];
      end
   end

   assign o_value = (i_reset_n && !i_clk && i_ce && i_load) ? src_word : r_value;

endmodule

// File: rtl/address_bus_latch_bank.sv
// 6502 address-output register: per-lane loads with phi1 transparency, full-width
// increment and a deferred page-cross carry that is applied to lane 1 one edge later.
module address_bus_latch_bank
   import cpu6502_addr_pkg::*;
#(
   parameter int                          LANE_W      = LANE_W_DEFAULT,
   parameter int                          NUM_LANES   = 2,
   parameter int                          NUM_SRC     = 4,
   parameter logic [LANE_W*NUM_LANES-1:0] RESET_VALUE = '0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   address_bus_latch_bank_if.slave bus
);

   localparam int SEL_W = sel_w(NUM_SRC);

   logic              any_load;
   logic              fixup_pending;
   logic              carry [NUM_LANES+1];
   logic [LANE_W-1:0] lane_value [NUM_LANES];
   logic              unused_top_carry;

   assign any_load         = |bus.i_load;
   assign carry[0]         = 1'b0;
   assign unused_top_carry = carry[NUM_LANES];

   // Increment feeds lane 0 only when nothing loads; the pending fix-up feeds lane 1.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic lane_add;

      if (l == 0) begin : g_add_inc
         assign lane_add = bus.i_inc & ~any_load;
      end else if (l == 1) begin : g_add_fix
         assign lane_add = fixup_pending;
      end else begin : g_add_none
         assign lane_add = 1'b0;
      end

      address_bus_lane #(
         .LANE_W      (LANE_W),
         .NUM_SRC     (NUM_SRC),
         .SEL_W       (SEL_W),
         .RESET_VALUE (RESET_VALUE[l*LANE_W +: LANE_W])
      ) u_lane (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_ce      (bus.i_ce),
         .i_src     (bus.i_src),
         .i_sel     (bus.i_sel[l*SEL_W +: SEL_W]),
         .i_load    (bus.i_load[l]),
         .i_add     (lane_add),
         .i_carry   (carry[l]),
         .o_carry   (carry[l+1]),
         .o_value   (lane_value[l])
      );
   end

   always_comb begin
      bus.o_address = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bus.o_address[l*LANE_W +: LANE_W] = lane_value[l];
      end
   end

   // Pending is consumed on every enabled edge; a fresh lane-0 carry re-arms it.
   if (NUM_LANES > 1) begin : g_fixup
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            fixup_pending <= 1'b0;
         end else if (bus.i_ce) begin
            fixup_pending <= bus.i_load[0] & bus.i_carry_in;
         end
      end
   end else begin : g_no_fixup
      logic unused_carry_in;
      assign unused_carry_in = bus.i_carry_in;
      assign fixup_pending   = 1'b0;
   end

   assign bus.o_fixup_pending = fixup_pending;

endmodule

// File: tb/tb_address_bus_latch_bank.sv
// Directed and random checks of the address latch bank against a byte/word
// level model of its load, increment and page-cross fix-up behaviour.
module tb_address_bus_latch_bank;
   import cpu6502_addr_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   logic [15:0] mAddr    = 16'h0000;
   logic        mPending = 1'b0;

   address_bus_latch_bank_if bus_if ();

   address_bus_latch_bank dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] makeSrc(input logic [7:0] db, adl, adh, sb);
      return {sb, adh, adl, db};
   endfunction

   function automatic logic [7:0] srcByte(input logic [31:0] src, input logic [1:0] sel);
      return src[int'(sel)*8 +: 8];
   endfunction

   // Address pins during phi1: loading lanes pass their source straight through.
   function automatic logic [15:0] phi1Expected();
      logic [15:0] e;
      e = mAddr;
      if (bus_if.i_ce && bus_if.i_load[0]) e[7:0]  = srcByte(bus_if.i_src, bus_if.i_sel[1:0]);
      if (bus_if.i_ce && bus_if.i_load[1]) e[15:8] = srcByte(bus_if.i_src, bus_if.i_sel[3:2]);
      return e;
   endfunction

   task automatic modelEdge();
      logic [7:0] lo, hi;
      if (!bus_if.i_ce) return;
      lo = mAddr[7:0];
      hi = mAddr[15:8];
      if (|bus_if.i_load) begin
         if (bus_if.i_load[0]) lo = srcByte(bus_if.i_src, bus_if.i_sel[1:0]);
         if (bus_if.i_load[1]) hi = srcByte(bus_if.i_src, bus_if.i_sel[3:2]);
         else if (mPending)    hi = hi + 8'd1;
         mAddr = {hi, lo};
      end else begin
         mAddr = mAddr + (bus_if.i_inc ? 16'd1 : 16'd0) + (mPending ? 16'h0100 : 16'h0000);
      end
      mPending = bus_if.i_load[0] & bus_if.i_carry_in;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expAddr, input logic expPending);
      checks++;
      assert (bus_if.o_address === expAddr) else begin
         errors++;
         $error("[TB] FAIL %s address got %h want %h", tag, bus_if.o_address, expAddr);
      end
      checks++;
      assert (bus_if.o_fixup_pending === expPending) else begin
         errors++;
         $error("[TB] FAIL %s pending got %b want %b", tag, bus_if.o_fixup_pending, expPending);
      end
   endtask

   task automatic applyStimulus(input logic ce, input logic [1:0] load, input logic [1:0] sel0,
                                input logic [1:0] sel1, input logic inc, input logic carry,
                                input logic [31:0] src);
      @(negedge clk);
      bus_if.i_ce       = ce;
      bus_if.i_load     = load;
      bus_if.i_sel      = {sel1, sel0};
      bus_if.i_inc      = inc;
      bus_if.i_carry_in = carry;
      bus_if.i_src      = src;
   endtask

   // One full cycle: check the phi1 pass-through, then the latched phi2 state.
   task automatic runCycle(input string tag, input logic ce, input logic [1:0] load,
                           input logic [1:0] sel0, input logic [1:0] sel1, input logic inc,
                           input logic carry, input logic [31:0] src);
      applyStimulus(ce, load, sel0, sel1, inc, carry, src);
      #1 checkOutput({tag, "/phi1"}, phi1Expected(), mPending);
      @(posedge clk);
      modelEdge();
      #1 checkOutput({tag, "/phi2"}, mAddr, mPending);
   endtask

   initial begin
      bus_if.i_ce       = 1'b1;
      bus_if.i_load     = 2'b11;
      bus_if.i_sel      = 4'b1001;
      bus_if.i_inc      = 1'b0;
      bus_if.i_carry_in = 1'b1;
      bus_if.i_src      = makeSrc(8'h11, 8'h22, 8'h33, 8'h44);
      #2 checkOutput("T1_reset", 16'h0000, 1'b0);
      bus_if.i_load     = 2'b00;
      bus_if.i_carry_in = 1'b0;
      #1 reset_n = 1'b1;

      runCycle("T2_load",   1'b1, 2'b01, 2'(SRC_DB), 2'(SRC_DB), 1'b0, 1'b0, makeSrc(8'h5A, 8'h00, 8'h00, 8'h00));
      runCycle("T2_hold",   1'b1, 2'b00, 2'(SRC_DB), 2'(SRC_DB), 1'b0, 1'b0, makeSrc(8'hC3, 8'h00, 8'h00, 8'h00));
      runCycle("T2_ce_off", 1'b0, 2'b01, 2'(SRC_DB), 2'(SRC_DB), 1'b0, 1'b0, makeSrc(8'hA5, 8'h00, 8'h00, 8'h00));

      runCycle("T3_ld12FF", 1'b1, 2'b11, 2'(SRC_DB), 2'(SRC_ADH), 1'b0, 1'b0, makeSrc(8'hFF, 8'h00, 8'h12, 8'h00));
      runCycle("T3_inc",    1'b1, 2'b00, 2'(SRC_DB), 2'(SRC_DB),  1'b1, 1'b0, makeSrc(8'h00, 8'h00, 8'h00, 8'h00));
      runCycle("T3_ldFFFF", 1'b1, 2'b11, 2'(SRC_ADL), 2'(SRC_SB), 1'b0, 1'b0, makeSrc(8'h00, 8'hFF, 8'h00, 8'hFF));
      runCycle("T3_wrap",   1'b1, 2'b00, 2'(SRC_DB), 2'(SRC_DB),  1'b1, 1'b0, makeSrc(8'h00, 8'h00, 8'h00, 8'h00));
      checkOutput("T3_zero", 16'h0000, 1'b0);

      runCycle("T4_ld2000", 1'b1, 2'b11, 2'(SRC_DB), 2'(SRC_ADH), 1'b0, 1'b0, makeSrc(8'h00, 8'h00, 8'h20, 8'h00));
      runCycle("T4_carry",  1'b1, 2'b01, 2'(SRC_DB), 2'(SRC_DB),  1'b0, 1'b1, makeSrc(8'h10, 8'h00, 8'h00, 8'h00));
      checkOutput("T4_2010", 16'h2010, 1'b1);
      runCycle("T4_fixup",  1'b1, 2'b00, 2'(SRC_DB), 2'(SRC_DB),  1'b0, 1'b0, makeSrc(8'h00, 8'h00, 8'h00, 8'h00));
      checkOutput("T4_2110", 16'h2110, 1'b0);

      runCycle("T5_carry",  1'b1, 2'b01, 2'(SRC_DB), 2'(SRC_DB),  1'b0, 1'b1, makeSrc(8'h10, 8'h00, 8'h00, 8'h00));
      runCycle("T5_ldhi",   1'b1, 2'b10, 2'(SRC_DB), 2'(SRC_SB),  1'b0, 1'b0, makeSrc(8'h00, 8'h00, 8'h00, 8'h40));
      checkOutput("T5_4010", 16'h4010, 1'b0);
      runCycle("T5_arm",    1'b1, 2'b01, 2'(SRC_DB), 2'(SRC_DB),  1'b0, 1'b1, makeSrc(8'h80, 8'h00, 8'h00, 8'h00));
      runCycle("T5_rearm",  1'b1, 2'b01, 2'(SRC_ADL), 2'(SRC_DB), 1'b0, 1'b1, makeSrc(8'h00, 8'h90, 8'h00, 8'h00));
      checkOutput("T5_4190", 16'h4190, 1'b1);

      runCycle("T6_ld20FF", 1'b1, 2'b11, 2'(SRC_DB), 2'(SRC_ADH), 1'b0, 1'b1, makeSrc(8'hFF, 8'h00, 8'h20, 8'h00));
      for (int i = 0; i < 3; i++) begin
         runCycle("T6_gated", 1'b0, 2'b00, 2'(SRC_DB), 2'(SRC_DB), 1'b1, 1'b1, makeSrc(8'h00, 8'h00, 8'h00, 8'h00));
      end
      checkOutput("T6_held", 16'h20FF, 1'b1);
      runCycle("T6_incfix", 1'b1, 2'b00, 2'(SRC_DB), 2'(SRC_DB), 1'b1, 1'b0, makeSrc(8'h00, 8'h00, 8'h00, 8'h00));
      checkOutput("T6_2200", 16'h2200, 1'b0);

      applyStimulus(1'b1, 2'b11, 2'(SRC_SB), 2'(SRC_ADL), 1'b0, 1'b0, makeSrc(8'h00, 8'hBE, 8'h00, 8'hEF));
      #1 checkOutput("T7_transp", 16'hBEEF, 1'b0);
      reset_n = 1'b0;
      #1 checkOutput("T7_rst_snap", 16'h0000, 1'b0);
      bus_if.i_load = 2'b00;
      bus_if.i_ce   = 1'b0;
      #1 reset_n = 1'b1;
      mAddr    = 16'h0000;
      mPending = 1'b0;

      for (int i = 0; i < 300; i++) begin
         runCycle("RND", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
